// File: rtl/player_mcu_pkg.sv
// Shared definitions for the music-player sequencer: state encoding and default sizing.
package player_mcu_pkg;

  typedef enum logic [1:0] {
    S_RESET   = 2'd0,
    S_PAUSED  = 2'd1,
    S_PLAYING = 2'd2,
    S_NEXT    = 2'd3
  } state_t;

  localparam int unsigned DEF_NUM_SONGS    = 4;
  localparam int unsigned DEF_SONG_BITS    = 2;
  localparam int unsigned DEF_RESET_CYCLES = 2;

endpackage

// File: rtl/player_mcu_counter_n.sv
// Modulo-n enable counter; co marks the enabled cycle that completes n counts.
module counter_n #(
  parameter int unsigned n = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic co
);

  localparam int unsigned W = (n > 1) ? $clog2(n) : 1;

  logic [W-1:0] count;

  assign co = en && (count == W'(n - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (en) begin
      if (co) count <= '0;
      else    count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/player_mcu.sv
// Music-player sequencer: play/pause, song select and reader reset pulse generation.
// Optional macro PLAYER_MCU_AUTO_ADVANCE_EN: song_done advances to the next song and keeps playing.
module player_mcu
  import player_mcu_pkg::*;
#(
  parameter int unsigned NUM_SONGS    = DEF_NUM_SONGS,
  parameter int unsigned SONG_BITS    = DEF_SONG_BITS,
  parameter int unsigned RESET_CYCLES = DEF_RESET_CYCLES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 play_pause,
  input  logic                 next,
  input  logic                 song_done,
  output logic                 play,
  output logic [SONG_BITS-1:0] song,
  output logic                 reset_player
);

  state_t state, state_nxt;
  logic   resume, resume_nxt;
  logic   cnt_en, cnt_co;

  assign cnt_en = (state == S_RESET);

  counter_n #(.n(RESET_CYCLES)) u_reset_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (cnt_en),
    .co    (cnt_co)
  );

  always_comb begin
    state_nxt  = state;
    resume_nxt = resume;
    case (state)
      S_RESET: begin
        if (cnt_co) state_nxt = resume ? S_PLAYING : S_PAUSED;
      end
      S_PAUSED: begin
        if (next) begin
          state_nxt  = S_NEXT;
          resume_nxt = 1'b0;
        end else if (play_pause) begin
          state_nxt = S_PLAYING;
        end
      end
      S_PLAYING: begin
        if (next) begin
          state_nxt  = S_NEXT;
          resume_nxt = 1'b1;
        end else if (song_done) begin
`ifdef PLAYER_MCU_AUTO_ADVANCE_EN
          state_nxt  = S_NEXT;
          resume_nxt = 1'b1;
`else
          state_nxt  = S_RESET;
          resume_nxt = 1'b0;
`endif
        end else if (play_pause) begin
          state_nxt = S_PAUSED;
        end
      end
      S_NEXT: begin
        state_nxt = S_RESET;
      end
      default: state_nxt = S_RESET;
    endcase
  end

  // Outputs are registered from the next state so they change on the same edge as state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_RESET;
      resume       <= 1'b0;
      song         <= '0;
      play         <= 1'b0;
      reset_player <= 1'b1;
    end else begin
      state        <= state_nxt;
      resume       <= resume_nxt;
      play         <= (state_nxt == S_PLAYING);
      reset_player <= (state_nxt == S_RESET);
      if (state == S_NEXT) begin
        song <= (song == SONG_BITS'(NUM_SONGS - 1)) ? '0 : song + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_player_mcu.sv
// Self-checking bench for player_mcu: directed scenarios plus random pulses against a blackout-window model.
module tb_player_mcu;

  localparam int R  = 2;
  localparam int NS = 4;

  logic       clk = 1'b0;
  logic       reset, play_pause, next, song_done;
  logic       play, reset_player;
  logic [1:0] song;

  int passed = 0;
  int total  = 0;

  // Model: song index, playing flag, resume intent, and remaining cycles of a
  // "blackout" (R+1 = skip cycle pending, 1..R = reader held in reset).
  int m_song, m_blk;
  bit m_playing, m_resume;

  always #5 clk = ~clk;

  player_mcu #(.NUM_SONGS(NS), .SONG_BITS(2), .RESET_CYCLES(R)) dut (
    .clk          (clk),
    .reset        (reset),
    .play_pause   (play_pause),
    .next         (next),
    .song_done    (song_done),
    .play         (play),
    .song         (song),
    .reset_player (reset_player)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_song = 0; m_blk = R; m_playing = 0; m_resume = 0;
  endtask

  task automatic model_edge(input bit pp, input bit nx, input bit sd);
    if (m_blk > 0) begin
      if (m_blk == R + 1) m_song = (m_song + 1) % NS;
      m_blk--;
      if (m_blk == 0) m_playing = m_resume;
    end else if (!m_playing) begin
      if (nx) begin m_blk = R + 1; m_resume = 0; end
      else if (pp) m_playing = 1;
    end else begin
      if (nx) begin m_blk = R + 1; m_resume = 1; m_playing = 0; end
      else if (sd) begin
`ifdef PLAYER_MCU_AUTO_ADVANCE_EN
        m_blk = R + 1; m_resume = 1;
`else
        m_blk = R; m_resume = 0;
`endif
        m_playing = 0;
      end else if (pp) m_playing = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".play"},         {7'd0, play},         {7'd0, m_playing && m_blk == 0});
    chk({tag, ".reset_player"}, {7'd0, reset_player}, {7'd0, m_blk >= 1 && m_blk <= R});
    chk({tag, ".song"},         {6'd0, song},         8'(m_song));
  endtask

  // Called at a falling edge; applies pulses across one rising edge, checks #1 after it.
  task automatic step(input bit pp, input bit nx, input bit sd, input string tag);
    play_pause = pp; next = nx; song_done = sd;
    @(posedge clk);
    model_edge(pp, nx, sd);
    #1;
    check_all(tag);
    @(negedge clk);
    play_pause = 0; next = 0; song_done = 0;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(0, 0, 0, tag);
  endtask

  task automatic async_reset(input string tag);
    #2 reset = 0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    check_all(tag);
    reset = 1;
  endtask

  initial begin
    reset = 0; play_pause = 0; next = 0; song_done = 0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_all("rst_hold");
    end
    reset = 1;
    idle(2, "rst_release");
    idle(1, "paused");

    step(1, 0, 0, "pp_play");
    chk("pp_play.const", {7'd0, play}, 8'd1);
    step(1, 0, 0, "pp_pause");
    chk("pp_pause.const", {7'd0, reset_player}, 8'd0);
    step(1, 0, 0, "pp_play2");

    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0, "skip");
      idle(3, "skip_wait");
    end
    chk("song3.const", {6'd0, song}, 8'd3);
    step(0, 1, 0, "wrap_next");
    idle(3, "wrap_wait");
    chk("wrap.song", {6'd0, song}, 8'd0);
    chk("wrap.play", {7'd0, play}, 8'd1);

    step(0, 1, 0, "to_song1");
    idle(3, "to_song1_wait");
    step(0, 0, 1, "song_done");
    idle(3, "song_done_wait");
`ifdef PLAYER_MCU_AUTO_ADVANCE_EN
    chk("done.song", {6'd0, song}, 8'd2);
    chk("done.play", {7'd0, play}, 8'd1);
`else
    chk("done.song", {6'd0, song}, 8'd1);
    chk("done.play", {7'd0, play}, 8'd0);
    step(1, 0, 0, "resume_play");
`endif

    step(1, 1, 1, "all_three");
    idle(3, "all_three_wait");

    step(0, 1, 0, "next_then_rst");
    step(1, 1, 1, "pulse_in_next");
    step(1, 1, 1, "pulse_in_reset");
    async_reset("mid_reset");
    step(1, 1, 1, "pulse_after_rel");
    step(1, 0, 1, "pulse_after_rel2");
    idle(1, "settle");
    chk("settle.song", {6'd0, song}, 8'd0);
    step(0, 1, 1, "paused_next_pp");

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) == 0) begin
        async_reset("rand_rst");
      end else begin
        step($urandom_range(5) == 0, $urandom_range(9) == 0,
             $urandom_range(11) == 0, "rand");
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
